// File: rtl/lsu_pkg.sv
// Shared load/store definitions: func3 encodings, controller states, size decode.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;
  localparam logic [2:0] F3_BAD = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_RESP
  } state_t;

  // Access size in bytes from the low two func3 bits.
  function automatic logic [3:0] size_bytes(input logic [1:0] size_code);
    return 4'd1 << size_code;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: beat strobes, positioned store data and
// reassembled, size-masked, sign/zero-extended load data.
module lsu_lane_align #(
  parameter int XLEN = 64,
  localparam int NB  = XLEN / 8,
  localparam int OW  = $clog2(NB)
) (
  input  logic [OW-1:0]   off,
  input  logic [1:0]      size_code,
  input  logic            sign_ext,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata0,
  input  logic [XLEN-1:0] rdata1,
  output logic [NB-1:0]   strb0,
  output logic [NB-1:0]   strb1,
  output logic [XLEN-1:0] wdata0,
  output logic [XLEN-1:0] wdata1,
  output logic [XLEN-1:0] ldata
);
  import lsu_pkg::*;

  localparam int LW = $clog2(XLEN);

  logic [OW+2:0]      bit_sh;
  logic [3:0]         nbytes;
  logic [NB-1:0]      base_mask;
  logic [2*NB-1:0]    lane_mask;
  logic [2*XLEN-1:0]  wide_w;
  logic [XLEN-1:0]    raw;
  logic [6:0]         nbits;
  logic               full;
  logic [XLEN-1:0]    vmask;
  logic [LW-1:0]      sbit;

  // A double-width window lets one shift cover both beats; the upper half is beat 1.
  always_comb begin
    bit_sh    = {off, 3'b000};
    nbytes    = size_bytes(size_code);
    base_mask = ({1'b0, nbytes} >= 5'(NB)) ? '1 : ((NB'(1) << nbytes) - NB'(1));
    lane_mask = {{NB{1'b0}}, base_mask} << off;
    strb0     = lane_mask[NB-1:0];
    strb1     = lane_mask[2*NB-1:NB];
    wide_w    = {{XLEN{1'b0}}, wdata} << bit_sh;
    wdata0    = wide_w[XLEN-1:0];
    wdata1    = wide_w[2*XLEN-1:XLEN];
    raw       = XLEN'({rdata1, rdata0} >> bit_sh);
    nbits     = 7'd8 << size_code;
    full      = (nbits >= 7'(XLEN));
    vmask     = full ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
    sbit      = full ? LW'(XLEN - 1) : LW'(nbits - 7'd1);
    ldata     = (raw & vmask) | ((sign_ext && raw[sbit]) ? ~vmask : '0);
  end

endmodule

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller: accepts one request, issues one or two
// aligned memory beats, and returns the extended result to writeback.
//
// state | meaning
// IDLE  | ready for a new request
// REQ0  | first beat offered to memory
// WAIT0 | waiting for first beat completion
// REQ1  | second beat offered (boundary-crossing access)
// WAIT1 | waiting for second beat completion
// RESP  | result held until writeback accepts it
module lsu_align_ctrl #(
  parameter int XLEN        = 64,
  parameter int AW          = 64,
  parameter int MISALIGN_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_wen_i,
  input  logic [2:0]      req_func3_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [4:0]      req_rd_i,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic            mem_wen_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [XLEN/8-1:0] mem_wstrb_o,
  input  logic            mem_rsp_valid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic [4:0]      resp_rd_o,
  output logic            resp_err_o,
  output logic            busy_o
);
  import lsu_pkg::*;

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  state_t            state_q, state_d;
  logic              wen_q;
  logic [2:0]        func3_q;
  logic [AW-1:0]     addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata0_q, rdata1_q;
  logic [4:0]        rd_q;
  logic              err_q;
  logic              cross_q;

  logic              accept;
  logic [3:0]        in_size;
  logic [OW-1:0]     in_off;
  logic              in_bad;
  logic              in_cross;
  logic              in_err;

  logic [AW-1:0]     beat0_addr, beat1_addr;
  logic [NB-1:0]     strb0, strb1;
  logic [XLEN-1:0]   wdata0, wdata1, ldata;

  assign req_ready_o = (state_q == S_IDLE) && !rst;
  assign accept      = req_valid_i && req_ready_o;
  assign beat0_addr  = {addr_q[AW-1:OW], {OW{1'b0}}};
  assign beat1_addr  = beat0_addr + AW'(NB);

  // Classify the incoming request: illegal size, lane-boundary crossing.
  always_comb begin
    in_size  = size_bytes(req_func3_i[1:0]);
    in_off   = req_addr_i[OW-1:0];
    in_bad   = (req_func3_i == F3_BAD) || ({1'b0, in_size} > 5'(NB));
    in_cross = (5'({1'b0, in_off}) + 5'(in_size)) > 5'(NB);
    in_err   = in_bad || (in_cross && (MISALIGN_EN == 0));
  end

  lsu_lane_align #(.XLEN(XLEN)) u_lane_align (
    .off       (addr_q[OW-1:0]),
    .size_code (func3_q[1:0]),
    .sign_ext  (!func3_q[2]),
    .wdata     (wdata_q),
    .rdata0    (rdata0_q),
    .rdata1    (rdata1_q),
    .strb0     (strb0),
    .strb1     (strb1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ldata     (ldata)
  );

  // State register; reset abandons any beat in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Request latches and per-beat read data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q    <= 1'b0;
      func3_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      cross_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (accept) begin
        wen_q    <= req_wen_i;
        func3_q  <= req_func3_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
        rd_q     <= req_rd_i;
        err_q    <= in_err;
        cross_q  <= in_cross;
        rdata0_q <= '0;
        rdata1_q <= '0;
      end
      if ((state_q == S_WAIT0) && mem_rsp_valid_i) rdata0_q <= mem_rdata_i;
      if ((state_q == S_WAIT1) && mem_rsp_valid_i) rdata1_q <= mem_rdata_i;
    end
  end

  // Next state and outputs; all beat/result fields read zero outside their states.
  always_comb begin
    state_d         = state_q;
    busy_o          = (state_q != S_IDLE);
    mem_req_valid_o = 1'b0;
    mem_wen_o       = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    mem_wstrb_o     = '0;
    resp_valid_o    = 1'b0;
    resp_rdata_o    = '0;
    resp_rd_o       = '0;
    resp_err_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = in_err ? S_RESP : S_REQ0;
      end
      S_REQ0: begin
        mem_req_valid_o = 1'b1;
        mem_wen_o       = wen_q;
        mem_addr_o      = beat0_addr;
        mem_wstrb_o     = strb0;
        mem_wdata_o     = wen_q ? wdata0 : '0;
        if (mem_req_ready_i) state_d = S_WAIT0;
      end
      S_WAIT0: begin
        if (mem_rsp_valid_i) state_d = cross_q ? S_REQ1 : S_RESP;
      end
      S_REQ1: begin
        mem_req_valid_o = 1'b1;
        mem_wen_o       = wen_q;
        mem_addr_o      = beat1_addr;
        mem_wstrb_o     = strb1;
        mem_wdata_o     = wen_q ? wdata1 : '0;
        if (mem_req_ready_i) state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (mem_rsp_valid_i) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        resp_rd_o    = rd_q;
        resp_err_o   = err_q;
        resp_rdata_o = (wen_q || err_q) ? '0 : ldata;
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
